// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scancode decoder: folds E0/F0/E1 prefixes into one key event per keystroke,
// filters status bytes and tracks modifiers. Build macro PS2DEC_TYPEMATIC_FILTER_EN drops repeated makes.
module ps2_scancode_decoder #(
  parameter int PAUSE_LEN = 7
) (
  input  logic       cclk,
  input  logic       cclk_rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       ev_pause,
  output logic       mod_shift,
  output logic       mod_ctrl,
  output logic       mod_alt,
  output logic       bat_ok,
  output logic [7:0] err_cnt
);

  localparam int CW = (PAUSE_LEN < 2) ? 1 : $clog2(PAUSE_LEN + 1);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          shift_l, shift_r, ctrl_n, ctrl_e, alt_n, alt_e;

  logic accept, is_err, is_pfx, is_status;
  logic key_hit, key_ext, key_brk, fake_shift, pause_done;
  logic suppress, emit;

  // Only one event can be pending, so a full event register stalls the byte stream.
  assign in_ready  = !ev_valid && !cclk_rst;
  assign mod_shift = shift_l | shift_r;
  assign mod_ctrl  = ctrl_n | ctrl_e;
  assign mod_alt   = alt_n | alt_e;

  // NOTE: every always_comb output gets a value on every path; a missed branch infers a latch.
  always_comb begin
    accept     = in_valid && in_ready;
    is_err     = (in_data == 8'h00) || (in_data == 8'hFF);
    is_pfx     = (in_data == 8'hE0) || (in_data == 8'hF0);
    is_status  = in_data inside {8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE};
    key_ext    = (state == EXT) || (state == EXT_BRK);
    key_brk    = (state == BRK) || (state == EXT_BRK);
    key_hit    = 1'b0;
    case (state)
      IDLE:              key_hit = accept && !is_err && !is_pfx && !is_status;
      EXT, BRK, EXT_BRK: key_hit = accept && !is_err && !is_pfx;
      default:           key_hit = 1'b0;
    endcase
    // E0 12 accompanies PrintScreen and is not a real shift.
    fake_shift = key_ext && (in_data == 8'h12);
    pause_done = accept && (state == PAUSE) && (cnt <= CW'(1));
  end

  assign emit = key_hit && !fake_shift && !suppress;

`ifdef PS2DEC_TYPEMATIC_FILTER_EN
  logic       last_vld;
  logic [8:0] last_key;

  assign suppress = last_vld && !key_brk && (last_key == {key_ext, in_data});

  always_ff @(posedge cclk) begin
    if (cclk_rst) begin
      last_vld <= 1'b0;
      last_key <= '0;
    end else if (pause_done) begin
      last_vld <= 1'b0;
    end else if (emit) begin
      last_vld <= !key_brk;
      last_key <= {key_ext, in_data};
    end
  end
`else
  assign suppress = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge cclk) begin
    if (cclk_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ev_valid <= 1'b0;
      ev_code  <= '0;
      ev_ext   <= 1'b0;
      ev_break <= 1'b0;
      ev_pause <= 1'b0;
      shift_l  <= 1'b0;
      shift_r  <= 1'b0;
      ctrl_n   <= 1'b0;
      ctrl_e   <= 1'b0;
      alt_n    <= 1'b0;
      alt_e    <= 1'b0;
      bat_ok   <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (ev_valid && ev_ready) ev_valid <= 1'b0;

      if (accept) begin
        case (state)
          IDLE: begin
            if (in_data == 8'hE0)      state <= EXT;
            else if (in_data == 8'hF0) state <= BRK;
            else if (in_data == 8'hE1) begin
              state <= PAUSE;
              cnt   <= CW'(PAUSE_LEN);
            end
            else if (in_data == 8'hAA) bat_ok <= 1'b1;
          end
          EXT: begin
            if (in_data == 8'hF0)      state <= EXT_BRK;
            else if (in_data != 8'hE0) state <= IDLE;
          end
          BRK: begin
            if (in_data == 8'hE0)      state <= EXT_BRK;
            else if (in_data != 8'hF0) state <= IDLE;
          end
          EXT_BRK: if (!is_pfx) state <= IDLE;
          PAUSE: begin
            // The rest of the Pause sequence is counted, never decoded.
            if (pause_done) begin
              state    <= IDLE;
              cnt      <= '0;
              ev_valid <= 1'b1;
              ev_code  <= 8'h77;
              ev_ext   <= 1'b0;
              ev_break <= 1'b0;
              ev_pause <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase

        if (is_err && (state != PAUSE) && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;

        if (key_hit && !fake_shift) begin
          case ({key_ext, in_data})
            9'h012:  shift_l <= !key_brk;
            9'h059:  shift_r <= !key_brk;
            9'h014:  ctrl_n  <= !key_brk;
            9'h114:  ctrl_e  <= !key_brk;
            9'h011:  alt_n   <= !key_brk;
            9'h111:  alt_e   <= !key_brk;
            default: ;
          endcase
        end

        if (emit) begin
          ev_valid <= 1'b1;
          ev_code  <= in_data;
          ev_ext   <= key_ext;
          ev_break <= key_brk;
          ev_pause <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Testbench for ps2_scancode_decoder: directed vector table, hand-written corner sequences,
// and random byte streams checked against a keystroke-level reference model.
module tb_ps2_scancode_decoder;

  localparam int PAUSE_LEN = 7;
  localparam int K_LSHIFT = 'h012, K_RSHIFT = 'h059, K_LCTRL = 'h014, K_RCTRL = 'h114;
  localparam int K_LALT = 'h011, K_RALT = 'h111;

  logic       cclk = 1'b0;
  logic       cclk_rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       ev_ready = 1'b0;
  logic       in_ready, ev_valid, ev_ext, ev_break, ev_pause;
  logic       mod_shift, mod_ctrl, mod_alt, bat_ok;
  logic [7:0] ev_code, err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 cclk = ~cclk;

  ps2_scancode_decoder #(.PAUSE_LEN(PAUSE_LEN)) dut (
    .cclk(cclk), .cclk_rst(cclk_rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_ext(ev_ext), .ev_break(ev_break), .ev_pause(ev_pause),
    .mod_shift(mod_shift), .mod_ctrl(mod_ctrl), .mod_alt(mod_alt),
    .bat_ok(bat_ok), .err_cnt(err_cnt)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%b expected=%b", name, act, exp);
    end
  endtask

  // ---------------- bus helpers ----------------
  task automatic xfer(input logic [7:0] b);
    int n = 0;
    @(negedge cclk);
    while (!in_ready && n < 50) begin
      @(negedge cclk);
      n++;
    end
    if (!in_ready) check_bit("in_ready wait timeout", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge cclk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic consume();
    @(negedge cclk);
    ev_ready = 1'b1;
    @(posedge cclk);
    #1;
    ev_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge cclk);
    cclk_rst = 1'b1;
    in_valid = 1'b0;
    ev_ready = 1'b0;
    @(posedge cclk);
    #1;
    check_bit("in_ready during reset", in_ready, 1'b0);
    @(posedge cclk);
    #1;
    check_bit("rst ev_valid", ev_valid, 1'b0);
    check("rst ev_code", ev_code, 8'h00);
    check_bit("rst ev_ext", ev_ext, 1'b0);
    check_bit("rst ev_break", ev_break, 1'b0);
    check_bit("rst ev_pause", ev_pause, 1'b0);
    check("rst mods", {5'd0, mod_shift, mod_ctrl, mod_alt}, 8'h00);
    check_bit("rst bat_ok", bat_ok, 1'b0);
    check("rst err_cnt", err_cnt, 8'h00);
    @(negedge cclk);
    cclk_rst = 1'b0;
    #1;
    check_bit("in_ready after reset", in_ready, 1'b1);
  endtask

  // ---------------- reference model (keystroke level) ----------------
  logic     m_ext, m_brk, m_in_pause, m_bat, m_last_vld;
  int       m_pause_left, m_err, m_last;
  bit       held[int];

  function automatic void model_reset();
    m_ext = 1'b0; m_brk = 1'b0; m_in_pause = 1'b0; m_bat = 1'b0; m_last_vld = 1'b0;
    m_pause_left = 0; m_err = 0; m_last = 0;
    held.delete();
  endfunction

  function automatic logic [2:0] model_mods();
    return {held.exists(K_LSHIFT) || held.exists(K_RSHIFT),
            held.exists(K_LCTRL)  || held.exists(K_RCTRL),
            held.exists(K_LALT)   || held.exists(K_RALT)};
  endfunction

  function automatic void model_step(input logic [7:0] b, output logic ev, output logic [7:0] code,
                                     output logic ext, output logic brk, output logic pse);
    int key;
    ev = 1'b0; code = 8'h00; ext = 1'b0; brk = 1'b0; pse = 1'b0;
    if (m_in_pause) begin
      m_pause_left--;
      if (m_pause_left <= 0) begin
        m_in_pause = 1'b0;
        m_last_vld = 1'b0;
        ev = 1'b1; code = 8'h77; pse = 1'b1;
      end
      return;
    end
    if (b == 8'h00 || b == 8'hFF) begin
      if (m_err < 255) m_err++;
      m_ext = 1'b0; m_brk = 1'b0;
      return;
    end
    if (b == 8'hE0) begin m_ext = 1'b1; return; end
    if (b == 8'hF0) begin m_brk = 1'b1; return; end
    if (!m_ext && !m_brk) begin
      if (b == 8'hE1) begin m_in_pause = 1'b1; m_pause_left = PAUSE_LEN; return; end
      if (b == 8'hAA) begin m_bat = 1'b1; return; end
      if (b inside {8'hFA, 8'hFE, 8'hEE}) return;
    end
    ext = m_ext; brk = m_brk;
    m_ext = 1'b0; m_brk = 1'b0;
    if (ext && b == 8'h12) begin ext = 1'b0; brk = 1'b0; return; end
    key = ext ? (256 + int'(b)) : int'(b);
    if (brk) held.delete(key);
    else held[key] = 1'b1;
`ifdef PS2DEC_TYPEMATIC_FILTER_EN
    if (brk) m_last_vld = 1'b0;
    else if (m_last_vld && m_last == key) begin ext = 1'b0; return; end
    else begin m_last_vld = 1'b1; m_last = key; end
`endif
    ev = 1'b1; code = b;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic       ev;
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       pause;
    logic [2:0] mods;   // {shift, ctrl, alt}
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t nx(input logic [7:0] d, input logic [2:0] m);
    vec_t v;
    v.data = d; v.ev = 1'b0; v.code = 8'h00; v.ext = 1'b0; v.brk = 1'b0; v.pause = 1'b0; v.mods = m;
    return v;
  endfunction

  function automatic vec_t ek(input logic [7:0] d, input logic x, input logic k, input logic p,
                              input logic [2:0] m);
    vec_t v;
    v.data = d; v.ev = 1'b1; v.code = p ? 8'h77 : d; v.ext = x; v.brk = k; v.pause = p; v.mods = m;
    return v;
  endfunction

  initial begin
    logic [7:0] rb, e_code, tseq[6];
    logic       e_ev, e_ext, e_brk, e_pse;
    logic [1:0] sel;
    logic [7:0] status_tab[4];
    logic [7:0] mod_tab[4];
    int         n_ev, exp_typ;
    int unsigned r, w;

    status_tab = '{8'hAA, 8'hFA, 8'hFE, 8'hEE};
    mod_tab    = '{8'h12, 8'h59, 8'h14, 8'h11};

    vecs.push_back(ek(8'h1C, 1'b0, 1'b0, 1'b0, 3'b000));
    vecs.push_back(nx(8'hF0, 3'b000));
    vecs.push_back(ek(8'h1C, 1'b0, 1'b1, 1'b0, 3'b000));
    vecs.push_back(nx(8'hE0, 3'b000));
    vecs.push_back(ek(8'h75, 1'b1, 1'b0, 1'b0, 3'b000));
    vecs.push_back(nx(8'hE0, 3'b000));
    vecs.push_back(nx(8'hF0, 3'b000));
    vecs.push_back(ek(8'h75, 1'b1, 1'b1, 1'b0, 3'b000));
    vecs.push_back(ek(8'h12, 1'b0, 1'b0, 1'b0, 3'b100));
    vecs.push_back(ek(8'h1C, 1'b0, 1'b0, 1'b0, 3'b100));
    vecs.push_back(nx(8'hF0, 3'b100));
    vecs.push_back(ek(8'h12, 1'b0, 1'b1, 1'b0, 3'b000));
    vecs.push_back(nx(8'hE0, 3'b000));
    vecs.push_back(nx(8'h12, 3'b000));
    vecs.push_back(nx(8'hE0, 3'b000));
    vecs.push_back(ek(8'h14, 1'b1, 1'b0, 1'b0, 3'b010));
    vecs.push_back(nx(8'hE0, 3'b010));
    vecs.push_back(nx(8'hF0, 3'b010));
    vecs.push_back(ek(8'h14, 1'b1, 1'b1, 1'b0, 3'b000));
    vecs.push_back(nx(8'hE1, 3'b000));
    vecs.push_back(nx(8'h14, 3'b000));
    vecs.push_back(nx(8'h77, 3'b000));
    vecs.push_back(nx(8'hE1, 3'b000));
    vecs.push_back(nx(8'hF0, 3'b000));
    vecs.push_back(nx(8'h14, 3'b000));
    vecs.push_back(nx(8'hF0, 3'b000));
    vecs.push_back(ek(8'h77, 1'b0, 1'b0, 1'b1, 3'b000));
    vecs.push_back(ek(8'h1C, 1'b0, 1'b0, 1'b0, 3'b000));
    vecs.push_back(ek(8'h11, 1'b0, 1'b0, 1'b0, 3'b001));
    vecs.push_back(ek(8'h59, 1'b0, 1'b0, 1'b0, 3'b101));
    vecs.push_back(nx(8'hF0, 3'b101));
    vecs.push_back(ek(8'h59, 1'b0, 1'b1, 1'b0, 3'b001));
    vecs.push_back(nx(8'hF0, 3'b001));
    vecs.push_back(ek(8'h11, 1'b0, 1'b1, 1'b0, 3'b000));
    vecs.push_back(nx(8'hAA, 3'b000));
    vecs.push_back(nx(8'hFA, 3'b000));
    vecs.push_back(nx(8'hFE, 3'b000));
    vecs.push_back(nx(8'hEE, 3'b000));
    vecs.push_back(nx(8'h00, 3'b000));
    vecs.push_back(nx(8'hE0, 3'b000));
    vecs.push_back(nx(8'hFF, 3'b000));
    vecs.push_back(ek(8'h1C, 1'b0, 1'b0, 1'b0, 3'b000));
    vecs.push_back(nx(8'hF0, 3'b000));
    vecs.push_back(nx(8'hE0, 3'b000));
    vecs.push_back(nx(8'hF0, 3'b000));
    vecs.push_back(ek(8'h7D, 1'b1, 1'b1, 1'b0, 3'b000));
    vecs.push_back(nx(8'hE0, 3'b000));
    vecs.push_back(ek(8'hAA, 1'b1, 1'b0, 1'b0, 3'b000));

    do_reset();

    foreach (vecs[i]) begin
      xfer(vecs[i].data);
      check_bit($sformatf("vec%0d ev_valid", i), ev_valid, vecs[i].ev);
      if (vecs[i].ev) begin
        check($sformatf("vec%0d ev_code", i), ev_code, vecs[i].code);
        check_bit($sformatf("vec%0d ev_ext", i), ev_ext, vecs[i].ext);
        check_bit($sformatf("vec%0d ev_break", i), ev_break, vecs[i].brk);
        check_bit($sformatf("vec%0d ev_pause", i), ev_pause, vecs[i].pause);
      end
      check($sformatf("vec%0d mods", i), {5'd0, mod_shift, mod_ctrl, mod_alt}, {5'd0, vecs[i].mods});
      if (ev_valid) consume();
    end
    check_bit("table bat_ok", bat_ok, 1'b1);
    check("table err_cnt", err_cnt, 8'h02);

    // Back-pressure: the event is held, in_ready stays low, and the waiting byte is not lost.
    xfer(8'hE0);
    xfer(8'h75);
    check_bit("bp first ev_valid", ev_valid, 1'b1);
    @(negedge cclk);
    in_valid = 1'b1;
    in_data  = 8'hE0;
    for (int c = 0; c < 10; c++) begin
      @(negedge cclk);
      check_bit($sformatf("bp in_ready cycle %0d", c), in_ready, 1'b0);
    end
    check_bit("bp held ev_valid", ev_valid, 1'b1);
    check("bp held ev_code", ev_code, 8'h75);
    check_bit("bp held ev_ext", ev_ext, 1'b1);
    ev_ready = 1'b1;
    @(posedge cclk);
    #1;
    ev_ready = 1'b0;
    check_bit("bp ev_valid after take", ev_valid, 1'b0);
    check_bit("bp in_ready after take", in_ready, 1'b1);
    @(posedge cclk);
    #1;
    in_valid = 1'b0;
    check_bit("bp prefix no event", ev_valid, 1'b0);
    xfer(8'hF0);
    xfer(8'h75);
    check_bit("bp break ev_valid", ev_valid, 1'b1);
    check("bp break ev_code", ev_code, 8'h75);
    check_bit("bp break ev_ext", ev_ext, 1'b1);
    check_bit("bp break ev_break", ev_break, 1'b1);
    if (ev_valid) consume();

    // Status bytes, error saturation, then reset while a break prefix is pending.
    do_reset();
    n_ev = 0;
    xfer(8'hAA); if (ev_valid) begin n_ev++; consume(); end
    xfer(8'hFA); if (ev_valid) begin n_ev++; consume(); end
    xfer(8'h00); if (ev_valid) begin n_ev++; consume(); end
    check("err_cnt after 00", err_cnt, 8'h01);
    for (int k = 0; k < 300; k++) begin
      xfer(8'hFF);
      if (ev_valid) begin n_ev++; consume(); end
    end
    check("status events", 8'(n_ev), 8'd0);
    check_bit("status bat_ok", bat_ok, 1'b1);
    check("err_cnt saturated", err_cnt, 8'hFF);
    xfer(8'hF0);
    do_reset();
    xfer(8'h1C);
    check_bit("post-reset ev_valid", ev_valid, 1'b1);
    check("post-reset ev_code", ev_code, 8'h1C);
    check_bit("post-reset ev_break", ev_break, 1'b0);
    check_bit("post-reset ev_ext", ev_ext, 1'b0);
    if (ev_valid) consume();

    // Typematic repeats.
    do_reset();
    tseq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
    n_ev = 0;
    foreach (tseq[k]) begin
      xfer(tseq[k]);
      if (ev_valid) begin n_ev++; consume(); end
    end
`ifdef PS2DEC_TYPEMATIC_FILTER_EN
    exp_typ = 3;
`else
    exp_typ = 5;
`endif
    check("typematic event count", 8'(n_ev), 8'(exp_typ));

    // Random byte stream against the reference model.
    do_reset();
    model_reset();
    for (int k = 0; k < 800; k++) begin
      r = $urandom_range(0, 99);
      if (r < 12)      rb = 8'hE0;
      else if (r < 22) rb = 8'hF0;
      else if (r < 25) rb = 8'hE1;
      else if (r < 29) begin sel = 2'($urandom_range(0, 3)); rb = status_tab[sel]; end
      else if (r < 32) rb = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      else if (r < 52) begin sel = 2'($urandom_range(0, 3)); rb = mod_tab[sel]; end
      else             rb = 8'($urandom_range(1, 254));
      xfer(rb);
      model_step(rb, e_ev, e_code, e_ext, e_brk, e_pse);
      check_bit($sformatf("rnd%0d ev_valid (byte %h)", k, rb), ev_valid, e_ev);
      if (e_ev) begin
        check($sformatf("rnd%0d ev_code", k), ev_code, e_code);
        check_bit($sformatf("rnd%0d ev_ext", k), ev_ext, e_ext);
        check_bit($sformatf("rnd%0d ev_break", k), ev_break, e_brk);
        check_bit($sformatf("rnd%0d ev_pause", k), ev_pause, e_pse);
      end
      check($sformatf("rnd%0d mods", k), {5'd0, mod_shift, mod_ctrl, mod_alt}, {5'd0, model_mods()});
      check_bit($sformatf("rnd%0d bat_ok", k), bat_ok, m_bat);
      check($sformatf("rnd%0d err_cnt", k), err_cnt, 8'(m_err));
      if (ev_valid) begin
        w = $urandom_range(0, 3);
        repeat (w) begin
          @(negedge cclk);
          check_bit($sformatf("rnd%0d in_ready while pending", k), in_ready, 1'b0);
        end
        consume();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Converts the raw PS/2 set-2 byte stream from the keyboard receive FIFO into one key event per keystroke. Folds the E0, F0 and E1 prefixes into flags, filters keyboard status bytes, and tracks modifier state. Sits between the PS/2 receive byte FIFO and the keyboard SPAM register or any other event consumer.

## Interface

Parameters:
- PAUSE_LEN, 7: number of bytes swallowed after E1 (rest of the Pause sequence).

Ports:
- cclk  in  1  core clock.
- cclk_rst  in  1  synchronous, active-high reset.
- in_valid  in  1  scancode byte available.
- in_data  in  8  scancode byte.
- in_ready  out  1  byte accepted on cclk edge when in_valid && in_ready.
- ev_valid  out  1  event register full.
- ev_ready  in  1  consumer takes event when ev_valid && ev_ready.
- ev_code  out  8  base scancode.
- ev_ext  out  1  E0-prefixed key.
- ev_break  out  1  1 = release, 0 = press.
- ev_pause  out  1  Pause key event; ev_code=0x77, ev_ext=0, ev_break=0.
- mod_shift  out  1  left (12) or right (59) shift held.
- mod_ctrl  out  1  14 or E0 14 held.
- mod_alt  out  1  11 or E0 11 held.
- bat_ok  out  1  sticky; set on 0xAA received in IDLE.
- err_cnt  out  8  saturating count of 0x00/0xFF bytes.

## Operation

- in_ready = !ev_valid && !cclk_rst; combinational. At most one event is pending at a time.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> PAUSE and load the down-counter with PAUSE_LEN.
  - AA -> set bat_ok, no event.
  - FA, FE, EE -> dropped, no event.
  - 00 or FF -> err_cnt+1, no event.
  - Any other byte -> make event (ext=0, brk=0).
- EXT: F0 -> EXT_BRK; any other code -> event with ext=1, brk=0, then IDLE.
- BRK: code -> event with ext=0, brk=1, then IDLE.
- EXT_BRK: code -> event with ext=1, brk=1, then IDLE.
- PAUSE: each accepted byte decrements the counter. When the counter reaches 0, emit the pause event and return to IDLE. Bytes are not interpreted in this state.
- In EXT, BRK or EXT_BRK:
  - 00/FF increments err_cnt and returns to IDLE with no event.
  - Another E0 or F0 is treated as a prefix: E0 in BRK -> EXT_BRK, F0 in EXT -> EXT_BRK, duplicates are ignored.
- E0 12 and E0 F0 12 (fake shift, sent with PrintScreen) produce no event and do not touch mod_shift.
- Modifiers are set on make and cleared on break of the listed codes, ext-qualified. mod_shift = L | R, using separate internal bits. mod_ctrl and mod_alt each OR their non-ext and ext bits.
- err_cnt saturates at 0xFF.

## Timing

- Byte accepted at edge N -> ev_valid=1 and fields stable from edge N.
- The modifier update takes effect on the same edge.
- Event fields hold until the edge where ev_valid && ev_ready. ev_valid falls on that edge and in_ready rises in the same cycle.
- Prefix or filtered bytes take one cycle each and produce no ev_valid.
- Reset values:
  - state = IDLE, counter = 0.
  - All ev_* outputs = 0.
  - mod_* = 0, bat_ok = 0, err_cnt = 0.
  - in_ready = 0 during reset.
- Reset mid-sequence discards any partial prefix and any pending event.

## Configuration

- PS2DEC_TYPEMATIC_FILTER_EN defined:
  - Remember the last make event's {ext, code}.
  - A make event equal to it is suppressed, with no ev_valid.
  - Any break event, the pause event, or reset clears the memory.
- Not defined: every typematic repeat make byte produces an event.

## Test plan

- Send 1C, F0 1C -> two events: {1C, ext0, brk0} and {1C, ext0, brk1}; mod_* stay 0.
- Send E0 75, E0 F0 75 -> events {75, ext1, brk0} and {75, ext1, brk1}. With ev_ready held low for 10 cycles after the first event, in_ready must stay 0 and no byte is lost.
- Send 12, 1C, F0 12 -> mod_shift rises with the 12 event and falls with the break. E0 12 alone leaves mod_shift at 0 and emits no event.
- Send E1 14 77 E1 F0 14 F0 77 -> exactly one event: ev_pause=1, code 77. The next byte 1C decodes normally.
- Send AA, FA, 00, FF×300 -> bat_ok=1, no events, err_cnt=0xFF (saturated). Assert reset while in BRK; after reset, 1C yields a make event.
- With PS2DEC_TYPEMATIC_FILTER_EN, send 1C 1C 1C F0 1C 1C -> events: make, break, make (three total). Without the macro, six bytes produce five events.
